// File: rtl/cnn_fifo_pkg.sv
// Shared constants and helpers for the CNN activation/weight FIFO.
// Mode selectors for the FWFT parameter and an elaboration-time log2.
package cnn_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cnn_fifo_ram.sv
// Simple dual-port storage for cnn_sync_fifo: synchronous write, asynchronous read.
// The array carries no reset so it maps onto distributed or block RAM.
module cnn_fifo_ram
    import cnn_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              w_clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge w_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cnn_sync_fifo.sv
// Single-clock parametrised FIFO between the DMA/loader and the PE array,
// with optional first-word-fall-through, occupancy flags and sticky errors.
module cnn_sync_fifo
    import cnn_fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4096,
    parameter int FWFT      = FIFO_MODE_STD,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4
) (
    input  logic                  w_clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  w_en,
    input  logic [DATA_W-1:0]     din,
    input  logic                  r_en,
    output logic [DATA_W-1:0]     dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [clog2(DEPTH):0] count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_THRESH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cnn_sync_fifo: DEPTH must be a power of 2 and at least 4");
    end
    if (AE_THRESH >= AF_THRESH) begin : g_bad_thresh
        $error("cnn_sync_fifo: AE_THRESH must be below AF_THRESH");
    end

    logic [ADDR_W:0]   wptr;
    logic [ADDR_W:0]   rptr;
    logic [DATA_W-1:0] ram_rdata;
    logic              wr_ok;
    logic              rd_ok;

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // A pop frees a slot in the same cycle, so a full FIFO still takes a write alongside a read.
    assign rd_ok = r_en & ~empty & ~flush;
    assign wr_ok = w_en & (~full | rd_ok) & ~flush;

    always_ff @(posedge w_clk) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + ONE_C;
            end
            if (rd_ok) begin
                rptr <= rptr + ONE_C;
            end
            if (wr_ok && !rd_ok) begin
                count <= count + ONE_C;
            end else if (rd_ok && !wr_ok) begin
                count <= count - ONE_C;
            end
            if (w_en && !wr_ok) begin
                overflow <= 1'b1;
            end
            if (r_en && !rd_ok) begin
                underflow <= 1'b1;
            end
        end
    end

    cnn_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .w_clk (w_clk),
        .we    (wr_ok),
        .waddr (wptr[ADDR_W-1:0]),
        .wdata (din),
        .raddr (rptr[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Remembers the last head shown so dout holds steady once the FIFO drains.
        logic [DATA_W-1:0] held_head;

        always_ff @(posedge w_clk) begin
            if (reset) begin
                held_head <= '0;
            end else if (!empty) begin
                held_head <= ram_rdata;
            end
        end

        assign dout       = empty ? held_head : ram_rdata;
        assign dout_valid = ~empty;
    end else begin : g_std
        logic [DATA_W-1:0] dout_reg;
        logic              valid_reg;

        always_ff @(posedge w_clk) begin
            if (reset) begin
                dout_reg  <= '0;
                valid_reg <= 1'b0;
            end else begin
                valid_reg <= rd_ok;
                if (rd_ok) begin
                    dout_reg <= ram_rdata;
                end
            end
        end

        assign dout       = dout_reg;
        assign dout_valid = valid_reg;
    end

endmodule

// File: tb/tb_cnn_sync_fifo.sv
// Scoreboard bench for cnn_sync_fifo: a standard-mode and a FWFT instance share
// one stimulus stream and are checked against a queue-based occupancy model.
module tb_cnn_sync_fifo;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          w_clk;
    logic          reset;
    logic          flush;
    logic          w_en;
    logic [DW-1:0] din;
    logic          r_en;

    logic [DW-1:0] dout_s, dout_f;
    logic          dv_s, dv_f;
    logic          full_s, empty_s, af_s, ae_s, ovf_s, udf_s;
    logic          full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
    logic [3:0]    count_s, count_f;

    cnn_sync_fifo #(
        .DATA_W (DW), .DEPTH (DEPTH), .FWFT (0), .AF_THRESH (AF), .AE_THRESH (AE)
    ) dut_std (
        .w_clk (w_clk), .reset (reset), .flush (flush), .w_en (w_en), .din (din),
        .r_en (r_en), .dout (dout_s), .dout_valid (dv_s), .full (full_s),
        .empty (empty_s), .almost_full (af_s), .almost_empty (ae_s),
        .count (count_s), .overflow (ovf_s), .underflow (udf_s)
    );

    cnn_sync_fifo #(
        .DATA_W (DW), .DEPTH (DEPTH), .FWFT (1), .AF_THRESH (AF), .AE_THRESH (AE)
    ) dut_fwft (
        .w_clk (w_clk), .reset (reset), .flush (flush), .w_en (w_en), .din (din),
        .r_en (r_en), .dout (dout_f), .dout_valid (dv_f), .full (full_f),
        .empty (empty_f), .almost_full (af_f), .almost_empty (ae_f),
        .count (count_f), .overflow (ovf_f), .underflow (udf_f)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: FIFO contents, sticky errors and the expected read stream.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_std[$];
    logic          exp_std_valid = 1'b0;
    logic [DW-1:0] last_head     = '0;
    logic          model_ovf     = 1'b0;
    logic          model_udf     = 1'b0;
    logic          mon_en        = 1'b0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic we, input logic [DW-1:0] d, input logic re,
                                  input logic fl, input logic rst);
        int  n;
        logic rd_acc, wr_acc;
        reset = rst;
        flush = fl;
        w_en  = we;
        din   = d;
        r_en  = re;
        @(posedge w_clk);
        n = model_q.size();
        if (n > 0) last_head = model_q[0];
        exp_std_valid = 1'b0;
        if (rst) begin
            model_q.delete();
            exp_std.delete();
            model_ovf = 1'b0;
            model_udf = 1'b0;
            last_head = '0;
            mon_en    = 1'b1;
        end else if (fl) begin
            model_q.delete();
        end else begin
            rd_acc = re && (n > 0);
            wr_acc = we && ((n < DEPTH) || rd_acc);
            if (we && !wr_acc) model_ovf = 1'b1;
            if (re && !rd_acc) model_udf = 1'b1;
            if (rd_acc) begin
                exp_std.push_back(model_q.pop_front());
                exp_std_valid = 1'b1;
            end
            if (wr_acc) model_q.push_back(d);
        end
        @(negedge w_clk);
    endtask

    // Monitor: compares both instances against the model on every falling edge.
    always @(negedge w_clk) begin
        int n;
        if (mon_en) begin
            n = model_q.size();
            check_output("count_std", count_s, n);
            check_output("count_fwft", count_f, n);
            check_output("full", full_s, n == DEPTH);
            check_output("empty", empty_s, n == 0);
            check_output("almost_full", af_s, n >= AF);
            check_output("almost_empty", ae_s, n <= AE);
            check_output("overflow", ovf_s, model_ovf);
            check_output("underflow", udf_s, model_udf);
            check_output("dout_valid_std", dv_s, exp_std_valid);
            if (dv_s && exp_std.size() > 0) begin
                check_output("dout_std", dout_s, exp_std.pop_front());
            end
            check_output("dout_valid_fwft", dv_f, n != 0);
            check_output("dout_fwft", dout_f, (n != 0) ? model_q[0] : last_head);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] d;
        int            p_w;
        reset = 1'b1;
        flush = 1'b0;
        w_en  = 1'b0;
        din   = '0;
        r_en  = 1'b0;
        @(negedge w_clk);
        apply_stimulus(0, 0, 0, 0, 1);
        check_output("rst_dout_std", dout_s, 0);
        check_output("rst_dout_fwft", dout_f, 0);
        check_output("rst_empty", empty_s, 1);
        check_output("rst_ae", ae_s, 1);

        // Fill with 0x11..0x18, then one extra write overflows.
        for (int i = 0; i < 8; i++) apply_stimulus(1, DW'(8'h11 + i), 0, 0, 0);
        check_output("fill_full", full_s, 1);
        check_output("fill_count", count_s, 8);
        apply_stimulus(1, 8'h99, 0, 0, 0);
        check_output("fill_ovf", ovf_s, 1);
        check_output("fill_ovf_count", count_s, 8);

        // Drain with r_en held; standard dout trails each pop by one cycle.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(0, 0, 1, 0, 0);
            check_output("drain_dout", dout_s, 8'h11 + i);
        end
        check_output("drain_empty", empty_s, 1);
        apply_stimulus(0, 0, 1, 0, 0);
        check_output("drain_udf", udf_s, 1);

        // First-word fall-through latency.
        apply_stimulus(1, 8'hA5, 0, 0, 0);
        check_output("fwft_not_empty", empty_f, 0);
        check_output("fwft_head", dout_f, 8'hA5);
        apply_stimulus(0, 0, 1, 0, 0);
        check_output("fwft_popped_empty", empty_f, 1);

        // Threshold crossings while filling one word at a time.
        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(1, DW'(8'h30 + i), 0, 0, 0);
            if (i == 2) check_output("ae_at2", ae_s, 1);
            if (i == 3) check_output("ae_at3", ae_s, 0);
            if (i == 5) check_output("af_at5", af_s, 0);
            if (i == 6) check_output("af_at6", af_s, 1);
        end

        // Full FIFO with simultaneous push and pop across the pointer wrap.
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1, DW'(8'h60 + i), 1, 0, 0);
            check_output("wrap_count", count_s, 8);
        end
        for (int i = 0; i < 8; i++) apply_stimulus(0, 0, 1, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0);

        // Flush beats a concurrent write and read; sticky errors survive it.
        for (int i = 0; i < 5; i++) apply_stimulus(1, DW'(8'hC0 + i), 0, 0, 0);
        apply_stimulus(1, 8'hEE, 1, 1, 0);
        check_output("flush_count", count_s, 0);
        check_output("flush_empty", empty_s, 1);
        check_output("flush_ovf_kept", ovf_s, 1);
        check_output("flush_udf_kept", udf_s, 1);
        apply_stimulus(0, 0, 0, 0, 1);
        check_output("reset_ovf_clr", ovf_s, 0);
        check_output("reset_udf_clr", udf_s, 0);

        // Randomised traffic, alternating fill-biased and drain-biased phases.
        for (int i = 0; i < 600; i++) begin
            p_w = ((i / 50) % 2 == 0) ? 75 : 30;
            d   = DW'($urandom);
            apply_stimulus($urandom_range(99) < p_w, d, $urandom_range(99) < 50,
                           $urandom_range(99) < 2, $urandom_range(199) == 0);
        end
        apply_stimulus(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
